ptp_time_counter: RTL and testbench
===================================

PTP_TIME_COUNTER -- requirements
Module: ptp_time_counter

Interface
REQ-001: COUNTER_WIDTH, default 96, total counter width in bits (integer ns plus fraction).
REQ-002: COUNTER_FRACTION, default 32, fractional-ns bits; NS_W = COUNTER_WIDTH-COUNTER_FRACTION.
REQ-003: CLK_PERIOD_NS, default 8, nominal integer ns added per clock.
REQ-004: NUM_SNAP, default 4, number of independent snapshot channels.
REQ-005: TICK_BIT, default 29, bit of counter_val whose 0->1 transition generates tick_out.
REQ-006: Clocking and reset: one clock; reset is synchronous and active-high.
REQ-007: clk  in  1  sole clock; all state updates on rising edge.
REQ-008: reset  in  1  synchronous, active-high reset.
REQ-009: load_valid  in  1  one-cycle strobe; load absolute time.
REQ-010: load_value  in  COUNTER_WIDTH  absolute time to load; sampled with load_valid.
REQ-011: adj_valid  in  1  one-cycle strobe; apply one-shot offset.
REQ-012: adj_value  in  NS_W  signed two's-complement ns offset.
REQ-013: drift_wr  in  1  strobe; update per-cycle drift.
REQ-014: drift_value  in  COUNTER_FRACTION  signed fractional-ns drift per cycle.
REQ-015: snap_req  in  NUM_SNAP  per-channel capture request.
REQ-016: snap_ack  in  NUM_SNAP  per-channel consumer acknowledge.
REQ-017: snap_valid  out  NUM_SNAP  per-channel captured value available.
REQ-018: snap_value  out  NUM_SNAP*NS_W  captured ns; channel i at bits [i*NS_W +: NS_W].
REQ-019: snap_ovf  out  NUM_SNAP  sticky per-channel overwrite flag.
REQ-020: counter_val  out  NS_W  counter[COUNTER_WIDTH-1:COUNTER_FRACTION], registered.
REQ-021: tick_out  out  1  one-cycle pulse on counter_val[TICK_BIT] rising.

Function
REQ-022: Internal step register step = (CLK_PERIOD_NS << COUNTER_FRACTION) + sign_extend(drift_value), COUNTER_WIDTH wide.
REQ-023: drift_wr at edge N updates step at edge N; new step is used from edge N+1 onward.
REQ-024: Each edge with no load/adj: counter <= counter + step, modulo 2^COUNTER_WIDTH (wrap silently, no flag).
REQ-025: adj_valid sampled at edge N: counter <= counter + step + (sign_extend(adj_value) << COUNTER_FRACTION) at edge N.
REQ-026: load_valid sampled at edge N: counter <= load_value at edge N (no step added that cycle).
REQ-027: Priority: load_valid > adj_valid; simultaneous -> adj discarded, load applied.
REQ-028: Step addition registered (pipelined): the counter-update adder is the only full-width adder in the counter path; adj addition uses a separate pre-computed register where needed, at the same edge-N latency as in REQ-025.
REQ-029: Snapshot: snap_req[i] at edge N -> snap_value[i] <= counter_val value present before edge N; snap_valid[i] = 1 from edge N.
REQ-030: snap_valid[i] holds until snap_ack[i] sampled high while snap_valid[i] = 1; clears at that edge.
REQ-031: snap_req[i] while snap_valid[i] = 1 and no ack -> value overwritten, snap_valid stays 1, snap_ovf[i] set sticky.
REQ-032: snap_req[i] and snap_ack[i] at the same edge -> new capture wins, snap_valid stays 1, no overflow.
REQ-033: Channels are fully independent; simultaneous requests on all channels capture the same value.
REQ-034: tick_out = 1 for one cycle when registered counter_val[TICK_BIT] goes 0->1 between consecutive cycles, including via load/adj; no pulse on 1->0.

Reset
REQ-035: reset at edge -> counter = 0, step = CLK_PERIOD_NS<<COUNTER_FRACTION (drift 0), snap_valid = 0, snap_value = 0, snap_ovf = 0, tick_out = 0.
REQ-036: reset overrides load, adj, drift_wr and snap_req sampled at the same edge; reset mid-operation discards pending state.
REQ-037: First edge with reset low -> counter_val = CLK_PERIOD_NS.

Verification
REQ-038: Release reset, idle -> counter_val 8, 16, 24 on consecutive cycles; 8n at cycle n.
REQ-039: drift_value = 32'h8000_0000 (-0.5 ns) from counter_val 0 -> next increments 7.5 ns; counter_val sequence 7, 15, 22, 30.
REQ-040: counter_val = 1000, adj_value = -100 -> next counter_val = 908; then 916.
REQ-041: load_valid with load_value = {64'd5000, 32'h0} and adj_valid = 1 same edge -> counter_val 5000 then 5008; adj ignored.
REQ-042: snap_req[2] at counter_val 40 -> snap_value[2] = 40, snap_valid[2] = 1; second snap_req[2] at 64 with no ack -> snap_value[2] = 64, snap_ovf[2] = 1; snap_ack[2] -> snap_valid[2] = 0, snap_ovf[2] stays 1.
REQ-043: Load counter_val = 2^29 - 16 -> tick_out pulses exactly once, on the cycle counter_val first reaches 2^29; load of all-ones counter -> wraps to CLK_PERIOD_NS-based value without error.

Source files
------------

// File: rtl/ptp_time_counter.sv
// Free-running PTP time-of-day counter (integer ns + fractional ns) with load,
// one-shot offset, per-cycle drift trim, tick output and independent snapshot channels.
module ptp_time_counter #(
    parameter int COUNTER_WIDTH    = 96,
    parameter int COUNTER_FRACTION = 32,
    parameter int CLK_PERIOD_NS    = 8,
    parameter int NUM_SNAP         = 4,
    parameter int TICK_BIT         = 29,
    localparam int NS_W            = COUNTER_WIDTH - COUNTER_FRACTION
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    input  logic [COUNTER_WIDTH-1:0] load_value,
    input  logic                     adj_valid,
    input  logic [NS_W-1:0]          adj_value,
    input  logic                     drift_wr,
    input  logic [COUNTER_FRACTION-1:0] drift_value,
    input  logic [NUM_SNAP-1:0]      snap_req,
    input  logic [NUM_SNAP-1:0]      snap_ack,
    output logic [NUM_SNAP-1:0]      snap_valid,
    output logic [NUM_SNAP*NS_W-1:0] snap_value,
    output logic [NUM_SNAP-1:0]      snap_ovf,
    output logic [NS_W-1:0]          counter_val,
    output logic                     tick_out
);

    localparam logic [COUNTER_WIDTH-1:0] STEP_BASE =
        COUNTER_WIDTH'(CLK_PERIOD_NS) << COUNTER_FRACTION;
    localparam int TICK_POS = COUNTER_FRACTION + TICK_BIT;

    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] step_q, step_d;
    logic [COUNTER_WIDTH-1:0] inc;
    logic                     tick_q, tick_d;
    logic [NUM_SNAP-1:0]      snap_valid_q, snap_valid_d;
    logic [NUM_SNAP-1:0]      snap_ovf_q, snap_ovf_d;
    logic [NUM_SNAP*NS_W-1:0] snap_value_q, snap_value_d;

    always_comb begin
        step_d = step_q;
        if (drift_wr) begin
            step_d = STEP_BASE + {{NS_W{drift_value[COUNTER_FRACTION-1]}}, drift_value};
        end

        // The offset only touches the integer-ns field, so it folds into the
        // increment with a narrow adder; the counter keeps a single wide adder.
        inc = step_q;
        if (adj_valid) begin
            inc[COUNTER_WIDTH-1:COUNTER_FRACTION] =
                step_q[COUNTER_WIDTH-1:COUNTER_FRACTION] + adj_value;
        end

        cnt_d  = load_valid ? load_value : cnt_q + inc;
        tick_d = cnt_d[TICK_POS] & ~cnt_q[TICK_POS];

        snap_valid_d = snap_valid_q;
        snap_ovf_d   = snap_ovf_q;
        snap_value_d = snap_value_q;
        for (int i = 0; i < NUM_SNAP; i++) begin
            if (snap_req[i]) begin
                snap_value_d[i*NS_W +: NS_W] = cnt_q[COUNTER_WIDTH-1:COUNTER_FRACTION];
                snap_valid_d[i] = 1'b1;
                if (snap_valid_q[i] && !snap_ack[i]) begin
                    snap_ovf_d[i] = 1'b1;
                end
            end else if (snap_ack[i]) begin
                snap_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            step_q       <= STEP_BASE;
            tick_q       <= 1'b0;
            snap_valid_q <= '0;
            snap_ovf_q   <= '0;
            snap_value_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            tick_q       <= tick_d;
            snap_valid_q <= snap_valid_d;
            snap_ovf_q   <= snap_ovf_d;
            snap_value_q <= snap_value_d;
        end
    end

    assign counter_val = cnt_q[COUNTER_WIDTH-1:COUNTER_FRACTION];
    assign tick_out    = tick_q;
    assign snap_valid  = snap_valid_q;
    assign snap_ovf    = snap_ovf_q;
    assign snap_value  = snap_value_q;

endmodule

// File: tb/tb_ptp_time_counter.sv
// Bench for ptp_time_counter: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic model of the time counter.
module tb_ptp_time_counter;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid;
    logic [95:0]  load_value;
    logic         adj_valid;
    logic [63:0]  adj_value;
    logic         drift_wr;
    logic [31:0]  drift_value;
    logic [3:0]   snap_req;
    logic [3:0]   snap_ack;
    logic [3:0]   snap_valid;
    logic [255:0] snap_value;
    logic [3:0]   snap_ovf;
    logic [63:0]  counter_val;
    logic         tick_out;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    ptp_time_counter dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_value(load_value),
        .adj_valid(adj_valid), .adj_value(adj_value),
        .drift_wr(drift_wr), .drift_value(drift_value),
        .snap_req(snap_req), .snap_ack(snap_ack),
        .snap_valid(snap_valid), .snap_value(snap_value), .snap_ovf(snap_ovf),
        .counter_val(counter_val), .tick_out(tick_out)
    );

    always #5 clk = ~clk;

    // Reference model: time as a 96-bit fixed-point number, 32 fraction bits.
    logic [95:0] m_cnt  = '0;
    logic [95:0] m_step = 96'd8 << 32;
    bit          m_tick = 1'b0;
    bit          m_sv[4];
    bit          m_so[4];
    logic [63:0] m_snap[4];

    always @(posedge clk) begin
        logic [95:0] nxt;
        logic [63:0] old_ns;
        old_ns = m_cnt[95:32];
        if (reset) begin
            m_cnt  = '0;
            m_step = 96'd8 << 32;
            m_tick = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_sv[i] = 0; m_so[i] = 0; m_snap[i] = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (snap_req[i]) begin
                    if (m_sv[i] && !snap_ack[i]) m_so[i] = 1;
                    m_sv[i]   = 1;
                    m_snap[i] = old_ns;
                end else if (snap_ack[i]) begin
                    m_sv[i] = 0;
                end
            end
            if (load_valid)     nxt = load_value;
            else if (adj_valid) nxt = m_cnt + m_step + ({{32{adj_value[63]}}, adj_value} << 32);
            else                nxt = m_cnt + m_step;
            m_tick = nxt[61] && !m_cnt[61];
            m_cnt  = nxt;
            if (drift_wr) m_step = (96'd8 << 32) + {{64{drift_value[31]}}, drift_value};
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_counter_val", counter_val, m_cnt[95:32]);
            chk("cmp_tick", 64'(tick_out), 64'(m_tick));
            for (int i = 0; i < 4; i++) begin
                chk("cmp_snap_valid", 64'(snap_valid[i]), 64'(m_sv[i]));
                chk("cmp_snap_ovf", 64'(snap_ovf[i]), 64'(m_so[i]));
                chk("cmp_snap_value", snap_value[i*64 +: 64], m_snap[i]);
            end
        end
    end

    task automatic clk1();
        @(posedge clk);
        #1;
        load_valid = 0; adj_valid = 0; drift_wr = 0; snap_req = '0; snap_ack = '0;
    endtask

    initial begin
        int pulses;
        int a;
        reset = 1; load_valid = 0; load_value = '0; adj_valid = 0; adj_value = '0;
        drift_wr = 0; drift_value = '0; snap_req = '0; snap_ack = '0;

        // Reset state, with strobes that reset must override.
        load_valid = 1; load_value = {64'd77, 32'h0}; snap_req = 4'hF; drift_wr = 1; drift_value = 32'h4000_0000;
        clk1();
        clk1();
        chk_en = 1;
        chk("rst_counter_val", counter_val, 64'd0);
        chk("rst_snap_valid", 64'(snap_valid), 64'd0);
        chk("rst_snap_ovf", 64'(snap_ovf), 64'd0);
        chk("rst_tick", 64'(tick_out), 64'd0);

        reset = 0;
        clk1(); chk("run_8", counter_val, 64'd8);
        clk1(); chk("run_16", counter_val, 64'd16);
        clk1(); chk("run_24", counter_val, 64'd24);

        // Drift of -0.5 ns from zero.
        load_valid = 1; load_value = '0; drift_wr = 1; drift_value = 32'h8000_0000;
        clk1(); chk("drift_0", counter_val, 64'd0);
        clk1(); chk("drift_7", counter_val, 64'd7);
        clk1(); chk("drift_15", counter_val, 64'd15);
        clk1(); chk("drift_22", counter_val, 64'd22);
        clk1(); chk("drift_30", counter_val, 64'd30);

        // One-shot -100 ns offset.
        load_valid = 1; load_value = {64'd1000, 32'h0}; drift_wr = 1; drift_value = '0;
        clk1(); chk("adj_1000", counter_val, 64'd1000);
        adj_valid = 1; adj_value = -64'sd100;
        clk1(); chk("adj_908", counter_val, 64'd908);
        clk1(); chk("adj_916", counter_val, 64'd916);

        // Load beats adjust.
        load_valid = 1; load_value = {64'd5000, 32'h0}; adj_valid = 1; adj_value = 64'd300;
        clk1(); chk("load_5000", counter_val, 64'd5000);
        clk1(); chk("load_5008", counter_val, 64'd5008);

        // Snapshot channel 2: capture, overwrite, acknowledge.
        load_valid = 1; load_value = {64'd40, 32'h0};
        clk1();
        snap_req = 4'b0100;
        clk1();
        chk("snap_val_40", snap_value[128 +: 64], 64'd40);
        chk("snap_valid_1", 64'(snap_valid[2]), 64'd1);
        chk("snap_ovf_0", 64'(snap_ovf[2]), 64'd0);
        clk1(); clk1();
        chk("snap_at_64", counter_val, 64'd64);
        snap_req = 4'b0100;
        clk1();
        chk("snap_val_64", snap_value[128 +: 64], 64'd64);
        chk("snap_ovf_1", 64'(snap_ovf[2]), 64'd1);
        snap_ack = 4'b0100;
        clk1();
        chk("snap_ack_valid", 64'(snap_valid[2]), 64'd0);
        chk("snap_ack_ovf", 64'(snap_ovf[2]), 64'd1);

        // Tick crossing 2^29.
        load_valid = 1; load_value = {64'((64'd1 << 29) - 64'd16), 32'h0};
        clk1();
        chk("tick_load_quiet", 64'(tick_out), 64'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            clk1();
            if (tick_out) begin
                pulses++;
                chk("tick_at", counter_val, 64'd1 << 29);
            end
        end
        chk("tick_count", 64'(pulses), 64'd1);

        // Wrap from all ones.
        load_valid = 1; load_value = '1;
        clk1(); chk("wrap_ones", counter_val, 64'hFFFF_FFFF_FFFF_FFFF);
        clk1(); chk("wrap_7", counter_val, 64'd7);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 399) == 0);
            load_valid  = ($urandom_range(0, 39) == 0);
            load_value  = {32'h0, ($urandom_range(0, 1) == 1) ? 32'((32'd1 << 29) - $urandom_range(0, 80)) : $urandom(), $urandom()};
            adj_valid   = ($urandom_range(0, 14) == 0);
            a           = int'($urandom_range(0, 2000)) - 1000;
            adj_value   = {{32{a[31]}}, a};
            drift_wr    = ($urandom_range(0, 29) == 0);
            drift_value = $urandom();
            snap_req    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            snap_ack    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            clk1();
            reset = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
